// File: rtl/portal_mem_slave.sv
// portal_mem_slave: bus slave bridging word transactions to portal request/indication channels.
// Define PORTAL_TIMEOUT_EN to add a ready-wait timeout that returns an error response.
module portal_mem_slave #(
    parameter int ADDR_W  = 12,
    parameter int NUM_REQ = 3,
    parameter int NUM_IND = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       requestEnqV,
    output logic              EN_request,
    input  logic              RDY_requestEnq,
    output logic [1:0]        selectRequest,
    output logic              EN_indication,
    output logic [1:0]        selectIndication,
    input  logic [31:0]       indicationData,
    input  logic              RDY_indication,
    input  logic [31:0]       indIntrChannel,
    output logic              intr
);
    typedef enum logic [1:0] {IDLE, REQ_WAIT, IND_WAIT, RESP} state_t;
    state_t state;
    logic intrEnable;
    logic [15:0] errCount;
    logic [15:0] errInc;
    logic [ADDR_W-9:0] region;
    logic [5:0] idx;
    logic reqHit;
    logic indHit;
    logic ctrlOk;
    logic timedOut;
    logic unusedAddr;
    logic [31:0] ctrlData;

    assign region = req_addr[ADDR_W-1:8];
    assign idx = req_addr[7:2];
    assign unusedAddr = ^req_addr[1:0];
    assign reqHit = region == (ADDR_W-8)'(1) && req_write && 32'(idx) < NUM_REQ;
    assign indHit = region == (ADDR_W-8)'(2) && !req_write && 32'(idx) < NUM_IND;
    assign ctrlOk = region == '0 && (req_write ? (idx == 6'd2 || idx == 6'd5) : idx <= 6'd5);
    assign errInc = errCount + 16'(errCount != 16'hFFFF);

    always_comb
        ctrlData = idx == 6'd0 ? {31'd0, indIntrChannel != '0} :
                   idx == 6'd1 ? indIntrChannel :
                   idx == 6'd2 ? {31'd0, intrEnable} :
                   idx == 6'd3 ? 32'(NUM_REQ) :
                   idx == 6'd4 ? 32'(NUM_IND) :
                   {16'd0, errCount};

    // Strobes are gated by RST so a reset landing mid-wait never fires a handshake
    assign req_ready = state == IDLE;
    assign rsp_valid = !RST && state == RESP;
    assign EN_request = !RST && state == REQ_WAIT && RDY_requestEnq;
    assign EN_indication = !RST && state == IND_WAIT && RDY_indication;

`ifdef PORTAL_TIMEOUT_EN
    logic [15:0] waitCnt;
    assign timedOut = waitCnt == 16'(TIMEOUT - 1);
    always_ff @(posedge CLK)
        waitCnt <= (RST || state == IDLE || state == RESP) ? 16'd0 : waitCnt + 16'd1;
`else
    localparam int unusedTimeout = TIMEOUT;
    assign timedOut = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            intrEnable <= 1'b0;
            errCount <= '0;
            intr <= 1'b0;
            selectRequest <= '0;
            selectIndication <= '0;
            requestEnqV <= '0;
            rsp_rdata <= '0;
            rsp_err <= 1'b0;
        end else begin
            intr <= intrEnable && indIntrChannel != '0;
            case (state)
                IDLE: if (req_valid) begin
                    if (reqHit) begin
                        state <= REQ_WAIT;
                        selectRequest <= idx[1:0];
                        requestEnqV <= req_wdata;
                    end else if (indHit) begin
                        state <= IND_WAIT;
                        selectIndication <= idx[1:0];
                    end else begin
                        state <= RESP;
                        rsp_err <= !ctrlOk;
                        rsp_rdata <= ctrlOk && !req_write ? ctrlData : 32'd0;
                        if (!ctrlOk)
                            errCount <= errInc;
                        else if (req_write && idx == 6'd5)
                            errCount <= '0;
                        if (ctrlOk && req_write && idx == 6'd2)
                            intrEnable <= req_wdata[0];
                    end
                end
                REQ_WAIT, IND_WAIT: begin
                    if (state == REQ_WAIT ? RDY_requestEnq : RDY_indication) begin
                        state <= RESP;
                        rsp_err <= 1'b0;
                        rsp_rdata <= state == REQ_WAIT ? 32'd0 : indicationData;
                    end else if (timedOut) begin
                        state <= RESP;
                        rsp_err <= 1'b1;
                        rsp_rdata <= 32'hDEADBEEF;
                        errCount <= errInc;
                    end
                end
                default: if (rsp_ready) state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_portal_mem_slave.sv
// tb_portal_mem_slave: randomized transactions checked against an address-map reference model.
module tb_portal_mem_slave;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic req_valid = 1'b0;
    logic req_write = 1'b0;
    logic [11:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic rsp_ready = 1'b0;
    logic RDY_requestEnq = 1'b0;
    logic RDY_indication = 1'b0;
    logic [31:0] indicationData = '0;
    logic [31:0] indIntrChannel = '0;
    logic req_ready, rsp_valid, rsp_err, EN_request, EN_indication, intr;
    logic [31:0] rsp_rdata, requestEnqV;
    logic [1:0] selectRequest, selectIndication;
    int vectors = 0;
    int miscompares = 0;
    logic mEnable = 1'b0;
    logic [15:0] mErr = '0;
    int expEnReq = 0;
    int expEnInd = 0;
    int enReq = 0;
    int enInd = 0;
    logic expIntr = 1'b0;
    bit monOn = 1'b0;
    logic [11:0] addrTab [14] = '{12'h000, 12'h004, 12'h008, 12'h00C, 12'h010, 12'h014, 12'h018,
                                  12'h100, 12'h104, 12'h108, 12'h10C, 12'h200, 12'h204, 12'h208};

    always #5 CLK = ~CLK;

    portal_mem_slave #(.ADDR_W(12), .NUM_REQ(3), .NUM_IND(2), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .requestEnqV(requestEnqV), .EN_request(EN_request),
        .RDY_requestEnq(RDY_requestEnq), .selectRequest(selectRequest), .EN_indication(EN_indication),
        .selectIndication(selectIndication), .indicationData(indicationData),
        .RDY_indication(RDY_indication), .indIntrChannel(indIntrChannel), .intr(intr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge CLK) begin
        expIntr <= RST ? 1'b0 : (mEnable && indIntrChannel != 0);
        if (EN_request === 1'b1) enReq <= enReq + 1;
        if (EN_indication === 1'b1) enInd <= enInd + 1;
    end

    always @(negedge CLK) if (monOn) begin
        chk("intr", 32'(intr), 32'(expIntr));
        chk("enBoth", 32'(EN_request & EN_indication), 0);
    end

    // kind: 0 control ok, 1 error, 2 enqueue, 3 dequeue
    task automatic model(input bit wr, input logic [11:0] a, output int kind, output logic [31:0] rd);
        logic [11:0] w;
        w = {a[11:2], 2'b00};
        kind = 1;
        rd = 0;
        if (w >= 12'h100 && w < 12'h10C) kind = wr ? 2 : 1;
        else if (w >= 12'h200 && w < 12'h208) kind = wr ? 1 : 3;
        else if (wr) kind = (w == 12'h008 || w == 12'h014) ? 0 : 1;
        else begin
            case (w)
                12'h000: begin kind = 0; rd = 32'(indIntrChannel != 0); end
                12'h004: begin kind = 0; rd = indIntrChannel; end
                12'h008: begin kind = 0; rd = 32'(mEnable); end
                12'h00C: begin kind = 0; rd = 3; end
                12'h010: begin kind = 0; rd = 2; end
                12'h014: begin kind = 0; rd = 32'(mErr); end
                default: kind = 1;
            endcase
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic doTxn(input bit wr, input logic [11:0] a, input logic [31:0] wd,
                         input int rdyDly, input int rspDly, input logic [31:0] id);
        int kind;
        int k;
        logic [31:0] rd;
        logic [11:0] w;
        model(wr, a, kind, rd);
        k = 32'(a[7:2]);
        w = {a[11:2], 2'b00};
        req_valid = 1'b1;
        req_write = wr;
        req_addr = a;
        req_wdata = wd;
        #1 chk("req_ready", 32'(req_ready), 1);
        @(negedge CLK);
        req_valid = 1'b0;
        if (kind == 1) mErr = mErr + 16'(mErr != 16'hFFFF);
        if (kind == 0 && wr && w == 12'h008) mEnable = wd[0];
        if (kind == 0 && wr && w == 12'h014) mErr = 0;
        if (kind >= 2) begin
            for (int i = 0; i < rdyDly; i++) begin
                chk("waitNoStrobe", 32'(EN_request | EN_indication), 0);
                chk("waitNoRsp", 32'(rsp_valid), 0);
                @(negedge CLK);
            end
            if (kind == 2) RDY_requestEnq = 1'b1;
            else begin
                RDY_indication = 1'b1;
                indicationData = id;
                rd = id;
            end
            #1;
            if (kind == 2) begin
                chk("EN_request", 32'(EN_request), 1);
                chk("selectRequest", 32'(selectRequest), 32'(k));
                chk("requestEnqV", requestEnqV, wd);
                expEnReq++;
            end else begin
                chk("EN_indication", 32'(EN_indication), 1);
                chk("selectIndication", 32'(selectIndication), 32'(k));
                expEnInd++;
            end
            @(negedge CLK);
            RDY_requestEnq = 1'b0;
            RDY_indication = 1'b0;
            indicationData = $urandom;
        end
        chk("rsp_valid", 32'(rsp_valid), 1);
        chk("rsp_err", 32'(rsp_err), 32'(kind == 1));
        chk("rsp_rdata", rsp_rdata, rd);
        for (int j = 0; j < rspDly; j++) begin
            @(negedge CLK);
            chk("holdValid", 32'(rsp_valid), 1);
            chk("holdData", rsp_rdata, rd);
            chk("holdReady", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        chk("rspDone", 32'(rsp_valid), 0);
    endtask

    initial begin
        int pick;
        int waited;
        logic [11:0] a;
        repeat (2) @(negedge CLK);
        chk("rstRspValid", 32'(rsp_valid), 0);
        chk("rstEnReq", 32'(EN_request), 0);
        chk("rstEnInd", 32'(EN_indication), 0);
        chk("rstIntr", 32'(intr), 0);
        chk("rstSelReq", 32'(selectRequest), 0);
        chk("rstSelInd", 32'(selectIndication), 0);
        chk("rstEnqV", requestEnqV, 0);
        RST = 1'b0;
        monOn = 1'b1;
        doTxn(0, 12'h014, 0, 0, 0, 0);
        doTxn(1, 12'h104, 32'h12345678, 0, 0, 0);
        doTxn(0, 12'h200, 0, 5, 0, 32'hCAFE0001);
        doTxn(1, 12'h008, 1, 0, 0, 0);
        indIntrChannel = 2;
        @(negedge CLK);
        chk("intrOn", 32'(intr), 1);
        doTxn(0, 12'h004, 0, 0, 0, 0);
        indIntrChannel = 0;
        @(negedge CLK);
        chk("intrOff", 32'(intr), 0);
        doTxn(1, 12'h10C, 32'h55AA55AA, 0, 0, 0);
        doTxn(0, 12'h014, 0, 0, 0, 0);
        doTxn(1, 12'h014, 0, 0, 0, 0);
        doTxn(0, 12'h014, 0, 0, 0, 0);
        doTxn(0, 12'h00C, 0, 0, 4, 0);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = 12'h100;
        req_wdata = 32'hA5A5A5A5;
        @(negedge CLK);
        req_valid = 1'b0;
        RST = 1'b1;
        RDY_requestEnq = 1'b1;
        mEnable = 1'b0;
        mErr = 0;
        #1 chk("rstMidNoStrobe", 32'(EN_request), 0);
        @(negedge CLK);
        RST = 1'b0;
        RDY_requestEnq = 1'b0;
        chk("rstMidRspValid", 32'(rsp_valid), 0);
        chk("rstMidReqReady", 32'(req_ready), 1);
        chk("rstMidEnqV", requestEnqV, 0);
`ifdef PORTAL_TIMEOUT_EN
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = 12'h204;
        @(negedge CLK);
        req_valid = 1'b0;
        waited = 0;
        while (!rsp_valid && waited < 40) begin
            @(negedge CLK);
            waited++;
        end
        chk("toCycles", 32'(waited), 8);
        chk("toErr", 32'(rsp_err), 1);
        chk("toData", rsp_rdata, 32'hDEADBEEF);
        mErr = mErr + 16'd1;
        rsp_ready = 1'b1;
        @(negedge CLK);
        rsp_ready = 1'b0;
        doTxn(0, 12'h014, 0, 0, 0, 0);
`endif
        for (int t = 0; t < 150; t++) begin
            pick = $urandom_range(0, 17);
            a = pick < 14 ? addrTab[pick] : 12'($urandom);
            a[1:0] = 2'($urandom);
            indIntrChannel = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 4)) : 32'd0;
            doTxn(1'($urandom_range(0, 1)), a, $urandom, 32'($urandom_range(0, 4)),
                  32'($urandom_range(0, 3)), $urandom);
        end
        @(negedge CLK);
        chk("enReqCount", 32'(enReq), 32'(expEnReq));
        chk("enIndCount", 32'(enInd), 32'(expEnInd));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/portal_mem_slave.md
Name: portal_mem_slave

Overview:
- Memory-mapped slave between the host bus adapter and the portal top.
- Converts single-beat word read/write transactions into the portal's channel-select handshakes:
  - request enqueue: EN_request / selectRequest / requestEnqV
  - indication dequeue: EN_indication / selectIndication / indicationData
- Also exposes interrupt status and control registers, and drives the host interrupt line.

Parameters:
- ADDR_W, 12: transaction byte-address width.
- NUM_REQ, 3: number of implemented request channels (max 4).
- NUM_IND, 2: number of implemented indication channels (max 4).
- TIMEOUT, 1024: cycles to wait for portal ready before an error response. Used only with PORTAL_TIMEOUT_EN.

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-high
- req_valid  in  1  transaction request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1=write, 0=read
- req_addr  in  ADDR_W  byte address; bits [1:0] ignored
- req_wdata  in  32  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  32  read data (0 for writes)
- rsp_err  out  1  error flag on the response
- requestEnqV  out  32  request word to portal
- EN_request  out  1  enqueue strobe
- RDY_requestEnq  in  1  portal can accept on selectRequest
- selectRequest  out  2  request channel index
- EN_indication  out  1  dequeue strobe
- selectIndication  out  2  indication channel index
- indicationData  in  32  head word of selected indication channel
- RDY_indication  in  1  selected indication channel has data
- indIntrChannel  in  32  0 = no interrupt, else pending channel+1
- intr  out  1  host interrupt

Behaviour:
- Clock and reset: single clock CLK; RST synchronous, active-high.
- Values during reset: rsp_valid, EN_request, EN_indication, intr, intr_enable and err_count are 0. selectRequest, selectIndication and requestEnqV are 0. State is IDLE.
- Address map (offsets from req_addr):
  - 0x000 RO: intr_status = (indIntrChannel != 0)
  - 0x004 RO: indIntrChannel
  - 0x008 RW: intr_enable bit0; other bits read 0
  - 0x00C RO: NUM_REQ
  - 0x010 RO: NUM_IND
  - 0x014 RO: err_count (16-bit, saturating at 0xFFFF, zero-extended); any write clears it
  - 0x100+4k: write enqueues req_wdata to request channel k
  - 0x200+4k: read dequeues from indication channel k
- Error cases: any other address, a write to an RO register other than 0x014, a read at 0x1xx, a write at 0x2xx, or k >= NUM_REQ / NUM_IND. Result: rsp_err=1, rsp_rdata=0, no EN strobe, err_count+1.
- FSM states: IDLE, REQ_WAIT, IND_WAIT, RESP.
- IDLE:
  - req_ready=1; all other states drive 0.
  - On accept: control/error access → RESP next cycle with data loaded; request-region write → latch selectRequest=k and requestEnqV=wdata → REQ_WAIT; indication-region read → latch selectIndication=k → IND_WAIT.
- REQ_WAIT: EN_request = (state==REQ_WAIT) && RDY_requestEnq, a single-cycle pulse. On that pulse go to RESP with err=0.
- IND_WAIT: EN_indication = (state==IND_WAIT) && RDY_indication. In that cycle capture indicationData into rsp_rdata, then go to RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready, then return to IDLE. Back-to-back accept is allowed on the cycle after return.
- Latency: control read → rsp_valid 1 cycle after accept. Enqueue/dequeue with RDY already high → strobe 1 cycle after accept, rsp_valid 2 cycles after accept.
- At most one EN strobe per transaction. EN_request and EN_indication are never simultaneously high.
- selectRequest and selectIndication hold their last values after a transaction.
- Interrupt: intr is registered, intr <= intr_enable & (indIntrChannel != 0), so 1-cycle lag.
- Reset asserted mid-transaction: the FSM returns to IDLE, the pending response is dropped, and no EN strobe occurs in the reset cycle.

Optional Feature:
- Macro: PORTAL_TIMEOUT_EN.
- Defined: a 16-bit wait counter clears on entry to REQ_WAIT/IND_WAIT. If TIMEOUT cycles pass without RDY, the FSM goes to RESP with rsp_err=1, rsp_rdata=32'hDEADBEEF, no strobe, and err_count+1.
- Undefined: REQ_WAIT/IND_WAIT wait indefinitely, and the counter logic is absent.

Test Plan:
- Write 0x104 with data 0x12345678, RDY_requestEnq=1 → selectRequest=1, requestEnqV=0x12345678, one EN_request pulse 1 cycle after accept, then rsp_valid with err=0.
- Read 0x200 with RDY_indication held 0 for 5 cycles, then 1 and indicationData=0xCAFE0001 → selectIndication=0, EN_indication pulses once in the RDY cycle, rsp_rdata=0xCAFE0001.
- Write 0x008=1, then drive indIntrChannel=2 → intr=1 one cycle later; read 0x004 → 2; indIntrChannel=0 → intr=0 next cycle.
- Write 0x10C (k=3 ≥ NUM_REQ) → rsp_err=1, no EN_request; read 0x014 → 1; write 0x014 → subsequent read 0x014 returns 0.
- rsp_ready held 0 for 4 cycles on a control read → rsp_valid and rsp_rdata stable throughout, req_ready=0; RST asserted in REQ_WAIT → no EN_request, rsp_valid=0 the next cycle.
- With PORTAL_TIMEOUT_EN and TIMEOUT=8, read 0x204 with RDY_indication=0 → after 8 cycles rsp_err=1, rsp_rdata=0xDEADBEEF, err_count increments, no EN_indication.
